ram_mar_prog: RTL and testbench

Parametrised successor to the SAP-1 16x8 RAM/MAR. It holds a DEPTH = 2**ADDR_WIDTH by DATA_WIDTH memory and a memory address register loaded from the bus. It adds a front-panel programming sequencer: buttons are synchronised, each press writes one word, and the address can auto-increment after each write. It sits on the CPU bus beside the instruction register and program counter. Front-panel LEDs are driven from addr_out.

---
 rtl/sap_pkg.sv | 22 ++
 rtl/btn_sync_edge.sv | 46 ++++
 rtl/ram_mar_prog.sv | 165 ++++++++++++++++
 tb/tb_ram_mar_prog.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sap_pkg.sv
// ---------------------------------------------------------------------------
// sap_pkg
// Shared definitions for the SAP-style RAM/MAR block with front-panel
// programming: default widths and the programming sequencer state type.
// ---------------------------------------------------------------------------
package sap_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_ADDR_WIDTH = 4;
  localparam int DEF_BUS_WIDTH  = 8;

  // RUN is the normal CPU-bus mode; the P_ states belong to the
  // front-panel programming sequencer.
  typedef enum logic [2:0] {
    RUN     = 3'd0,
    P_IDLE  = 3'd1,
    P_WRITE = 3'd2,
    P_INC   = 3'd3,
    P_WAIT  = 3'd4
  } prog_state_t;

endpackage

// File: rtl/btn_sync_edge.sv
// ---------------------------------------------------------------------------
// btn_sync_edge
// Brings a raw front-panel button into the clock domain through a two-stage
// synchroniser and produces a single-cycle pulse on its rising edge.
//
// Ports:
//   i_clk    system clock
//   i_rst    asynchronous active-high reset
//   i_btn    raw, asynchronous button level
//   o_level  synchronised button level
//   o_pulse  one-cycle pulse, high during the cycle after the third rising
//            clock edge following the raw rise
// ---------------------------------------------------------------------------
module btn_sync_edge (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn,
  output logic o_level,
  output logic o_pulse
);

  logic r_sync1;
  logic r_sync2;
  logic r_prev;
  logic r_pulse;

  // The pulse is registered so downstream logic sees a glitch-free,
  // full-cycle strobe.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_prev  <= 1'b0;
      r_pulse <= 1'b0;
    end else begin
      r_sync1 <= i_btn;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2;
      r_pulse <= r_sync2 & ~r_prev;
    end
  end

  assign o_level = r_sync2;
  assign o_pulse = r_pulse;

endmodule

// File: rtl/ram_mar_prog.sv
// ---------------------------------------------------------------------------
// ram_mar_prog
// DEPTH x DATA_WIDTH RAM with a bus-loaded memory address register and a
// front-panel programming sequencer (press-to-write, optional address
// auto-increment with a sticky wrap flag).
//
// Ports:
//   i_clk              system clock
//   i_clear            asynchronous active-high reset (memory not cleared)
//   i_prog_mode        1 = front-panel programming, 0 = run (bus) mode
//   i_auto_inc         increment programming address after each write
//   i_dipswitch_addr   front-panel address
//   i_dipswitch_data   front-panel data
//   i_prog_load_btn    raw button: load programming address
//   i_prog_write_btn   raw button: write one word
//   i_bus_in           CPU bus input
//   i_load_mar         run mode: MAR <= bus_in
//   i_write_enable     run mode: mem[MAR] <= bus_in
//   i_output_enable    drive mem[addr_out] onto o_bus_out
//   o_bus_out          memory word or zero
//   o_addr_out         active address (MAR or programming address)
//   o_prog_busy        sequencer is mid-action
//   o_prog_wrap        sticky auto-increment wrap flag
// ---------------------------------------------------------------------------
module ram_mar_prog
  import sap_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int BUS_WIDTH  = DEF_BUS_WIDTH
) (
  input  logic                  i_clk,
  input  logic                  i_clear,
  input  logic                  i_prog_mode,
  input  logic                  i_auto_inc,
  input  logic [ADDR_WIDTH-1:0] i_dipswitch_addr,
  input  logic [DATA_WIDTH-1:0] i_dipswitch_data,
  input  logic                  i_prog_load_btn,
  input  logic                  i_prog_write_btn,
  input  logic [BUS_WIDTH-1:0]  i_bus_in,
  input  logic                  i_load_mar,
  input  logic                  i_write_enable,
  input  logic                  i_output_enable,
  output logic [DATA_WIDTH-1:0] o_bus_out,
  output logic [ADDR_WIDTH-1:0] o_addr_out,
  output logic                  o_prog_busy,
  output logic                  o_prog_wrap
);

  localparam int DEPTH = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [ADDR_WIDTH-1:0] r_mar;
  logic [ADDR_WIDTH-1:0] r_prog_addr;
  logic                  r_prog_wrap;
  prog_state_t           r_state;

  logic                  w_load_level;
  logic                  w_load_pulse;
  logic                  w_write_level;
  logic                  w_write_pulse;
  logic                  w_mem_we;
  logic [ADDR_WIDTH-1:0] w_mem_addr;
  logic [DATA_WIDTH-1:0] w_mem_data;
  logic [ADDR_WIDTH-1:0] w_addr;

  btn_sync_edge u_load_btn (
    .i_clk   (i_clk),
    .i_rst   (i_clear),
    .i_btn   (i_prog_load_btn),
    .o_level (w_load_level),
    .o_pulse (w_load_pulse)
  );

  btn_sync_edge u_write_btn (
    .i_clk   (i_clk),
    .i_rst   (i_clear),
    .i_btn   (i_prog_write_btn),
    .o_level (w_write_level),
    .o_pulse (w_write_pulse)
  );

  // Only two sources may write memory: the bus in RUN, and the sequencer
  // in P_WRITE. The P_WRITE write still lands on the edge that leaves for
  // RUN when prog_mode drops. Qualifying with clear means a pending write
  // is dropped the moment clear asserts.
  assign w_mem_we   = ~i_clear &
                      (((r_state == RUN) && i_write_enable) || (r_state == P_WRITE));
  assign w_mem_addr = (r_state == RUN) ? r_mar : r_prog_addr;
  assign w_mem_data = (r_state == RUN) ? i_bus_in[DATA_WIDTH-1:0] : i_dipswitch_data;

  always_ff @(posedge i_clk) begin
    if (w_mem_we) begin
      r_mem[w_mem_addr] <= w_mem_data;
    end
  end

  // Sequencer, MAR and programming address. In RUN, a simultaneous
  // load_mar/write_enable writes at the old MAR because the memory block
  // samples r_mar before this update lands.
  always_ff @(posedge i_clk or posedge i_clear) begin
    if (i_clear) begin
      r_state     <= RUN;
      r_mar       <= '0;
      r_prog_addr <= '0;
      r_prog_wrap <= 1'b0;
    end else begin
      case (r_state)
        RUN: begin
          if (i_load_mar) begin
            r_mar <= i_bus_in[ADDR_WIDTH-1:0];
          end
          if (i_prog_mode) begin
            r_state     <= P_IDLE;
            r_prog_addr <= r_mar;
            r_prog_wrap <= 1'b0;
          end
        end
        P_IDLE: begin
          if (!i_prog_mode) begin
            r_state <= RUN;
          end else if (w_write_pulse) begin
            r_state <= P_WRITE;
          end else if (w_load_pulse) begin
            r_prog_addr <= i_dipswitch_addr;
            r_state     <= P_WAIT;
          end
        end
        P_WRITE: begin
          r_state <= i_prog_mode ? P_INC : RUN;
        end
        P_INC: begin
          if (!i_prog_mode) begin
            r_state <= RUN;
          end else begin
            if (i_auto_inc) begin
              r_prog_addr <= r_prog_addr + 1'b1;
              if (r_prog_addr == '1) begin
                r_prog_wrap <= 1'b1;
              end
            end
            r_state <= P_WAIT;
          end
        end
        P_WAIT: begin
          if (!i_prog_mode) begin
            r_state <= RUN;
          end else if (!w_load_level && !w_write_level) begin
            r_state <= P_IDLE;
          end
        end
        default: begin
          r_state <= RUN;
        end
      endcase
    end
  end

  assign w_addr      = (r_state == RUN) ? r_mar : r_prog_addr;
  assign o_addr_out  = w_addr;
  assign o_bus_out   = i_output_enable ? r_mem[w_addr] : '0;
  assign o_prog_busy = (r_state != RUN) && (r_state != P_IDLE);
  assign o_prog_wrap = r_prog_wrap;

endmodule

// File: tb/tb_ram_mar_prog.sv
module tb_ram_mar_prog;

  localparam int DW    = 8;
  localparam int AW    = 4;
  localparam int BW    = 8;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          clear;
  logic          prog_mode;
  logic          auto_inc;
  logic [AW-1:0] dipswitch_addr;
  logic [DW-1:0] dipswitch_data;
  logic          prog_load_btn;
  logic          prog_write_btn;
  logic [BW-1:0] bus_in;
  logic          load_mar;
  logic          write_enable;
  logic          output_enable;
  logic [DW-1:0] bus_out;
  logic [AW-1:0] addr_out;
  logic          prog_busy;
  logic          prog_wrap;

  always #5 clk = ~clk;

  ram_mar_prog #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .BUS_WIDTH(BW)) dut (
    .i_clk            (clk),
    .i_clear          (clear),
    .i_prog_mode      (prog_mode),
    .i_auto_inc       (auto_inc),
    .i_dipswitch_addr (dipswitch_addr),
    .i_dipswitch_data (dipswitch_data),
    .i_prog_load_btn  (prog_load_btn),
    .i_prog_write_btn (prog_write_btn),
    .i_bus_in         (bus_in),
    .i_load_mar       (load_mar),
    .i_write_enable   (write_enable),
    .i_output_enable  (output_enable),
    .o_bus_out        (bus_out),
    .o_addr_out       (addr_out),
    .o_prog_busy      (prog_busy),
    .o_prog_wrap      (prog_wrap)
  );

  typedef struct {
    logic          ld;
    logic          we;
    logic          oe;
    logic [BW-1:0] bus;
    logic [AW-1:0] expAddr;
    logic [DW-1:0] expOut;
  } vec_t;

  vec_t vecs[8];

  int nChecks = 0;
  int nFail   = 0;

  // Behavioural reference: memory image, MAR, programming address, wrap flag.
  logic [DW-1:0] modelMem [DEPTH];
  logic [AW-1:0] modelMar;
  logic [AW-1:0] modelProgAddr;
  logic          modelWrap;

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    nChecks++;
    if (actual !== expected) begin
      nFail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One table vector: strobes held for exactly one clock, outputs checked
  // just after that edge with the vector's output_enable still applied.
  task automatic applyStimulus(input int idx);
    load_mar      = vecs[idx].ld;
    write_enable  = vecs[idx].we;
    output_enable = vecs[idx].oe;
    bus_in        = vecs[idx].bus;
    tick();
    checkOutput($sformatf("vec%0d addr_out", idx), 32'(addr_out), 32'(vecs[idx].expAddr));
    checkOutput($sformatf("vec%0d bus_out", idx), 32'(bus_out), 32'(vecs[idx].expOut));
    load_mar      = 1'b0;
    write_enable  = 1'b0;
    output_enable = 1'b0;
  endtask

  task automatic runLoadMar(input logic [BW-1:0] v);
    bus_in   = v;
    load_mar = 1'b1;
    tick();
    load_mar = 1'b0;
    modelMar = v[AW-1:0];
  endtask

  task automatic runWrite(input logic [BW-1:0] v);
    bus_in       = v;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
    modelMem[modelMar] = v[DW-1:0];
  endtask

  task automatic checkRead(input string name, input logic [AW-1:0] a);
    logic [BW-1:0] busVal;
    busVal = '0;
    busVal[AW-1:0] = a;
    runLoadMar(busVal);
    output_enable = 1'b1;
    #1;
    checkOutput(name, 32'(bus_out), 32'(modelMem[a]));
    output_enable = 1'b0;
  endtask

  task automatic enterProg();
    prog_mode = 1'b1;
    tick();
    modelProgAddr = modelMar;
    modelWrap     = 1'b0;
  endtask

  task automatic exitProg();
    prog_mode = 1'b0;
    tick();
  endtask

  // One front-panel action as the operator sees it: a write stores a word
  // and optionally advances the address; a load alone sets the address.
  task automatic pressButtons(input logic w, input logic l, input logic [DW-1:0] data,
                              input logic [AW-1:0] addr, input int hold);
    dipswitch_data = data;
    dipswitch_addr = addr;
    prog_write_btn = w;
    prog_load_btn  = l;
    repeat (hold) tick();
    prog_write_btn = 1'b0;
    prog_load_btn  = 1'b0;
    repeat (8) tick();
    if (w) begin
      modelMem[modelProgAddr] = data;
      if (auto_inc) begin
        if (int'(modelProgAddr) == DEPTH - 1) modelWrap = 1'b1;
        modelProgAddr = AW'((int'(modelProgAddr) + 1) % DEPTH);
      end
    end else if (l) begin
      modelProgAddr = addr;
    end
  endtask

  task automatic checkProgView(input string name);
    output_enable = 1'b1;
    #1;
    checkOutput({name, " addr_out"}, 32'(addr_out), 32'(modelProgAddr));
    checkOutput({name, " wrap"}, 32'(prog_wrap), 32'(modelWrap));
    checkOutput({name, " busy"}, 32'(prog_busy), 32'd0);
    checkOutput({name, " bus_out"}, 32'(bus_out), 32'(modelMem[modelProgAddr]));
    output_enable = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [AW-1:0] savedMar;
    logic [DW-1:0] oldWord;

    vecs[0] = '{ld:1, we:0, oe:0, bus:8'h0C, expAddr:4'hC, expOut:8'h00};
    vecs[1] = '{ld:0, we:1, oe:1, bus:8'h9E, expAddr:4'hC, expOut:8'h9E};
    vecs[2] = '{ld:1, we:0, oe:0, bus:8'h03, expAddr:4'h3, expOut:8'h00};
    vecs[3] = '{ld:0, we:1, oe:1, bus:8'hA7, expAddr:4'h3, expOut:8'hA7};
    vecs[4] = '{ld:0, we:0, oe:0, bus:8'h00, expAddr:4'h3, expOut:8'h00};
    vecs[5] = '{ld:1, we:1, oe:1, bus:8'h5C, expAddr:4'hC, expOut:8'h9E};
    vecs[6] = '{ld:1, we:0, oe:1, bus:8'hF3, expAddr:4'h3, expOut:8'h5C};
    vecs[7] = '{ld:0, we:1, oe:1, bus:8'h00, expAddr:4'h3, expOut:8'h00};

    clear          = 1'b1;
    prog_mode      = 1'b0;
    auto_inc       = 1'b0;
    dipswitch_addr = '0;
    dipswitch_data = '0;
    prog_load_btn  = 1'b0;
    prog_write_btn = 1'b0;
    bus_in         = '0;
    load_mar       = 1'b0;
    write_enable   = 1'b0;
    output_enable  = 1'b0;
    modelMar       = '0;
    modelProgAddr  = '0;
    modelWrap      = 1'b0;

    repeat (3) tick();
    checkOutput("reset addr_out", 32'(addr_out), 32'd0);
    checkOutput("reset busy", 32'(prog_busy), 32'd0);
    checkOutput("reset wrap", 32'(prog_wrap), 32'd0);
    checkOutput("reset bus_out gated", 32'(bus_out), 32'd0);
    clear = 1'b0;
    tick();

    runLoadMar(8'h05);
    checkOutput("load_mar 5", 32'(addr_out), 32'd5);

    for (int i = 0; i < 8; i++) applyStimulus(i);
    modelMar = 4'h3;

    // Give the whole memory a known image before random traffic.
    for (int i = 0; i < DEPTH; i++) begin
      runLoadMar(BW'(i));
      runWrite(BW'($urandom));
    end

    for (int i = 0; i < 150; i++) begin
      logic          ld, we, oe;
      logic [BW-1:0] b;
      ld = 1'($urandom);
      we = 1'($urandom);
      oe = 1'($urandom);
      b  = BW'($urandom);
      load_mar = ld; write_enable = we; output_enable = oe; bus_in = b;
      tick();
      if (we) modelMem[modelMar] = b[DW-1:0];
      if (ld) modelMar = b[AW-1:0];
      checkOutput($sformatf("rand run %0d addr_out", i), 32'(addr_out), 32'(modelMar));
      checkOutput($sformatf("rand run %0d bus_out", i), 32'(bus_out),
                  32'(oe ? modelMem[modelMar] : 8'h00));
      load_mar = 1'b0; write_enable = 1'b0; output_enable = 1'b0;
    end

    // Auto-increment across the top of memory.
    runLoadMar(8'h07);
    savedMar = 4'h7;
    enterProg();
    auto_inc = 1'b1;
    pressButtons(1'b0, 1'b1, 8'h00, 4'hE, 2);
    checkOutput("prog load E", 32'(addr_out), 32'hE);
    pressButtons(1'b1, 1'b0, 8'h11, 4'h0, 2);
    pressButtons(1'b1, 1'b0, 8'h22, 4'h0, 2);
    pressButtons(1'b1, 1'b0, 8'h33, 4'h0, 2);
    checkOutput("autoinc addr_out", 32'(addr_out), 32'h1);
    checkOutput("autoinc wrap", 32'(prog_wrap), 32'd1);
    checkOutput("autoinc busy", 32'(prog_busy), 32'd0);
    exitProg();
    checkOutput("exit prog addr_out=MAR", 32'(addr_out), 32'(savedMar));
    checkOutput("wrap sticky in RUN", 32'(prog_wrap), 32'd1);
    checkOutput("mem[E] model", 32'(modelMem[4'hE]), 32'h11);
    checkRead("read mem[E]", 4'hE);
    checkRead("read mem[F]", 4'hF);
    checkRead("read mem[0]", 4'h0);

    // Held write button: exactly one write, busy until release.
    enterProg();
    checkOutput("wrap cleared on entry", 32'(prog_wrap), 32'd0);
    pressButtons(1'b0, 1'b1, 8'h00, 4'h5, 2);
    auto_inc       = 1'b1;
    dipswitch_data = 8'hC4;
    prog_write_btn = 1'b1;
    repeat (20) tick();
    checkOutput("hold busy", 32'(prog_busy), 32'd1);
    prog_write_btn = 1'b0;
    repeat (8) tick();
    modelMem[4'h5] = 8'hC4;
    modelProgAddr  = 4'h6;
    checkProgView("hold once");

    // Both buttons together: write wins at the current address.
    auto_inc = 1'b0;
    pressButtons(1'b1, 1'b1, 8'h6B, 4'h9, 3);
    checkProgView("both buttons");

    // Bus strobes are inert while programming.
    bus_in = 8'hFF; write_enable = 1'b1; load_mar = 1'b1;
    repeat (5) tick();
    checkOutput("prog ignores bus addr", 32'(addr_out), 32'(modelProgAddr));
    prog_mode = 1'b0; write_enable = 1'b0; load_mar = 1'b0;
    tick();
    checkOutput("MAR preserved", 32'(addr_out), 32'(modelMar));
    output_enable = 1'b1;
    #1;
    checkOutput("mem at MAR preserved", 32'(bus_out), 32'(modelMem[modelMar]));
    output_enable = 1'b0;

    // Random front-panel sessions.
    enterProg();
    for (int i = 0; i < 40; i++) begin
      int kind;
      kind     = $urandom_range(0, 9);
      auto_inc = 1'($urandom);
      pressButtons(kind < 6 || kind == 9, kind >= 6, DW'($urandom), AW'($urandom),
                   $urandom_range(1, 5));
      checkProgView($sformatf("rand prog %0d", i));
    end
    exitProg();
    for (int i = 0; i < DEPTH; i++) checkRead($sformatf("readback %0d", i), AW'(i));

    // Clear while the sequencer is in P_WRITE: that write must not land.
    enterProg();
    auto_inc = 1'b0;
    pressButtons(1'b0, 1'b1, 8'h00, 4'hA, 2);
    oldWord        = modelMem[4'hA];
    dipswitch_data = ~oldWord;
    prog_write_btn = 1'b1;
    repeat (4) tick();
    checkOutput("pre-clear busy", 32'(prog_busy), 32'd1);
    clear = 1'b1;
    #1;
    checkOutput("clear busy", 32'(prog_busy), 32'd0);
    checkOutput("clear addr_out", 32'(addr_out), 32'd0);
    prog_mode      = 1'b0;
    prog_write_btn = 1'b0;
    repeat (2) tick();
    clear         = 1'b0;
    modelMar      = '0;
    modelProgAddr = '0;
    modelWrap     = 1'b0;
    tick();
    checkOutput("clear wrap", 32'(prog_wrap), 32'd0);
    checkRead("aborted write", 4'hA);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
